// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register stage with multicycle settle window for an external multiplier
// Registers multiplier operands, waits SETTLE_CYCLES, captures the product into HI/LO.
module hilo_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] OP_A,
  input  logic [DATA_WIDTH-1:0] OP_B,
  input  logic                  FLUSH,
  input  logic                  MTHI,
  input  logic                  MTLO,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic [DATA_WIDTH-1:0] MULT_A,
  output logic [DATA_WIDTH-1:0] MULT_B,
  input  logic [DATA_WIDTH-1:0] PROD_HI,
  input  logic [DATA_WIDTH-1:0] PROD_LO,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SETTLE = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [0:0] state;
  logic [3:0] cnt;

  // BUSY is the registered state bit itself, so it never glitches with inputs.
  assign BUSY = state[0];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      MULT_A <= '0;
      MULT_B <= '0;
      HI     <= '0;
      LO     <= '0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MTHI) HI <= WDATA;
          if (MTLO) LO <= WDATA;
          if (START && !FLUSH) begin
            MULT_A <= OP_A;
            MULT_B <= OP_B;
            cnt    <= CNT_LOAD;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (FLUSH) begin
            state <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Operands have been stable for SETTLE_CYCLES edges; product is valid.
            HI    <= PROD_HI;
            LO    <= PROD_LO;
            DONE  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - bench for hilo_unit with a signed 32x32 multiplier stand-in
// Directed and random steps checked each cycle against a transaction-level reference.
module tb_hilo_unit;

  localparam int W = 32;
  localparam int SETTLE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          flush = 1'b0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  mult_a, mult_b, prod_hi, prod_lo, hi, lo;
  logic          busy, done;
  logic [63:0]   prod;

  always #5 clk = ~clk;

  // Stand-in for MULT32: signed 32x32 -> 64 product.
  assign prod = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
  assign prod_hi = prod[63:32];
  assign prod_lo = prod[31:0];

  hilo_unit #(.DATA_WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(clk), .RST(rst), .START(start), .OP_A(op_a), .OP_B(op_b),
    .FLUSH(flush), .MTHI(mthi), .MTLO(mtlo), .WDATA(wdata),
    .MULT_A(mult_a), .MULT_B(mult_b), .PROD_HI(prod_hi), .PROD_LO(prod_lo),
    .HI(hi), .LO(lo), .BUSY(busy), .DONE(done)
  );

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference: in-flight flag, edges remaining until capture, latched operands.
  logic [W-1:0] m_a, m_b, m_hi, m_lo;
  logic         m_busy, m_done;
  int           m_left;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic f, input logic wh, input logic wl, input logic [W-1:0] wd);
    longint pa, pb, p;
    if (!r) begin
      m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
        if (s && !f) begin
          m_a = a; m_b = b; m_busy = 1'b1; m_left = SETTLE;
        end
      end else if (f) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          pa = longint'($signed(m_a));
          pb = longint'($signed(m_b));
          p = pa * pb;
          m_hi = p[63:32]; m_lo = p[31:0];
          m_done = 1'b1; m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic f, input logic wh, input logic wl, input logic [W-1:0] wd);
    rst = r; start = s; op_a = a; op_b = b; flush = f; mthi = wh; mtlo = wl; wdata = wd;
    @(posedge clk);
    model_edge(r, s, a, b, f, wh, wl, wd);
    cyc++;
    #1;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mult_a", mult_a, m_a);
    chk("mult_b", mult_b, m_b);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    cycle(1'b1, 1'b1, a, b, 1'b0, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    // Reset with random inputs for two edges
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    chk("rst_hi", hi, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);

    // 5 x -7
    go(32'd5, -32'sd7);
    idle(3);
    chk("settle_busy", {31'd0, busy}, 32'h1);
    idle(1);
    chk("mul_done", {31'd0, done}, 32'h1);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFDD);
    idle(1);
    chk("done_pulse", {31'd0, done}, 32'h0);

    // Back-to-back: second start in the DONE cycle
    go(32'd1, 32'hFFFF_FFFF);
    idle(4);
    chk("b2b1_hi", hi, 32'hFFFF_FFFF);
    chk("b2b1_lo", lo, 32'hFFFF_FFFF);
    go(32'd8, 32'd7);
    idle(4);
    chk("b2b2_done", {31'd0, done}, 32'h1);
    chk("b2b2_hi", hi, 32'h0);
    chk("b2b2_lo", lo, 32'h38);

    // Flush in the 2nd busy cycle
    go(32'd3, 32'd9);
    idle(1);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'h0);
    idle(6);
    chk("flush_lo", lo, 32'h38);

    // MTHI/MTLO rules
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    chk("mthi", hi, 32'h1234_5678);
    go(32'd4, 32'd4);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("mtlo_busy", lo, 32'h38);
    idle(4);
    cycle(1'b1, 1'b1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
    chk("mtlo_start", lo, 32'hCAFE_0001);
    idle(4);
    chk("mtlo_over_lo", lo, 32'd6);
    chk("mtlo_over_hi", hi, 32'd0);

    // Reset in the 3rd busy cycle, then a normal multiply
    go(32'd11, 32'd13);
    idle(2);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mid_rst_a", mult_a, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    idle(5);
    go(32'hFFFF_FFFE, 32'hFFFF_FFFD);
    idle(4);
    chk("post_rst_lo", lo, 32'd6);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0), $urandom, $urandom,
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), $urandom);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
